stoch_win_count: RTL and testbench
==================================

Name: stoch_win_count

Overview:
- Downstream consumer of the windowed bit-insertion stage.
- Counts 1s in the stochastic bitstream over each power-of-two window.
- Emits the ones count and the equivalent fractional probability, in the same FBITWIDTH format as the insertion stage's iProb, with a one-cycle valid pulse per completed window.
- Used to close the loop on, and monitor, the probability actually delivered by the insertion stage.

Parameters:
BITWIDTH, 8, width of window size and ones counter
BITWIDTHLOG2, 3, width of window log2 input
FBITWIDTH, 4, fractional probability width; 0.5 = {0,1,0..0}, MSB never set

Ports:
iClk  input  1  clock
iRstN  input  1  asynchronous active-low reset
iClr  input  1  synchronous clear of all internal state and outputs
iEn  input  1  enable, same signal driving the upstream insertion stage
iWindow  input  BITWIDTH  window length, must equal 2^iWINLOG2
iWINLOG2  input  BITWIDTHLOG2  log2 of window, legal range 1..BITWIDTH-1
iA  input  1  stochastic bit from the upstream stage's registered output
oCnt  output  BITWIDTH  ones count of the last completed window
oProb  output  FBITWIDTH  probability of the last completed window
oValid  output  1  one-cycle pulse: oCnt/oProb updated this cycle
oSat  output  1  last window's probability saturated (all ones)

Behaviour:
- Reset (iRstN=0, async): enD, ones, idx, winLen, winLog, oCnt, oProb, oValid, oSat all 0.
- Alignment: enD <= iEn every cycle. Counting uses enD, not iEn, to match the upstream stage's one-cycle registered output.
  - The first counted bit is iA in the cycle after iEn is first seen high.
- Window start (idx==0 with enD=1): latch winLen<=iWindow, winLog<=iWINLOG2. Changes to the window inputs mid-window are ignored until the next window.
- Per enabled cycle:
  - ones <= ones + iA
  - idx <= idx+1
- Last bit (idx==winLen-1):
  - onesFinal = ones + iA.
  - Next cycle: oCnt <= onesFinal; oProb computed from onesFinal; oValid <= 1.
  - ones <= 0 and idx <= 0 in the same edge, so there are no dead cycles between windows.
- oValid is high for exactly one cycle per window. oCnt/oProb/oSat hold until the next window completes.
- Arithmetic:
  - scaled = (onesFinal << (FBITWIDTH-1)) >> winLog, computed at width BITWIDTH+FBITWIDTH, truncating.
  - If scaled >= 2^(FBITWIDTH-1): oProb = 2^(FBITWIDTH-1)-1 and oSat=1.
  - Else: oProb = scaled and oSat=0.
- iEn low: next cycle enD=0. ones and idx cleared, and the partial window is discarded (no oValid). Outputs hold their last values.
- iClr=1: same edge clears enD-independent state: ones, idx, oCnt, oProb, oSat, oValid all 0.
  - iClr has priority over a simultaneous last bit: no valid pulse.
- iEn re-asserted after a drop: behaves as a fresh start, including the alignment cycle.
- FSM, 2 states:
  - IDLE (enD=0) -> COUNT when enD=1.
  - COUNT -> IDLE on enD=0 or iClr.
  - COUNT self-loops across window boundaries.

Optional Feature:
ERROR_CHECK_EN: adds input iProb (FBITWIDTH) and outputs oErr (FBITWIDTH) and oMatch (1).
- iProb is latched at window start.
- With the macro defined, oErr = |oProb - iProbLatched| and oMatch = (oErr==0), both updated with oValid, cleared by reset/iClr.
- Without it, the ports are absent and there is no comparison logic.

Test Plan:
- Assert iRstN=0 mid-window with ones=5 -> all outputs 0 immediately; no oValid until a full new window completes.
- iWINLOG2=3, iWindow=8, iA=1 constant, iEn high -> oValid 9 cycles after iEn rise; oCnt=8, oProb=4'b0111, oSat=1.
- iWINLOG2=4, iWindow=16, iA alternating 1,0 -> oValid every 16 cycles; oCnt=8, oProb=4'b0100, oSat=0.
- iWINLOG2=3, iA pattern 1,1,1,0,0,0,0,0 -> oCnt=3, oProb=4'b0011; then iWINLOG2=2/iWindow=4 applied mid-window -> takes effect only from the next window.
- iEn dropped after 5 bits, re-raised 3 cycles later -> no oValid for the partial window; the next window counts only bits after the new alignment cycle.
- iClr asserted on the last bit of a window -> oValid stays 0; oCnt=oProb=0. With ERROR_CHECK_EN, iProb=4'b0011 against measured 4'b0100 -> oErr=1, oMatch=0.

Source files
------------

// File: rtl/stoch_win_count_if.sv
// Bitstream input, window configuration and result strobe of stoch_win_count.
// With ERROR_CHECK_EN defined it also carries iProb (requested probability) and oErr/oMatch.
interface stoch_win_count_if #(
    parameter int BITWIDTH     = 8,
    parameter int BITWIDTHLOG2 = 3,
    parameter int FBITWIDTH    = 4
);
    logic                    iClr;
    logic                    iEn;
    logic [BITWIDTH-1:0]     iWindow;
    logic [BITWIDTHLOG2-1:0] iWINLOG2;
    logic                    iA;
    logic [BITWIDTH-1:0]     oCnt;
    logic [FBITWIDTH-1:0]    oProb;
    logic                    oValid;
    logic                    oSat;
`ifdef ERROR_CHECK_EN
    logic [FBITWIDTH-1:0]    iProb;
    logic [FBITWIDTH-1:0]    oErr;
    logic                    oMatch;
`endif

    modport master (
`ifdef ERROR_CHECK_EN
        output iProb,
        input  oErr, oMatch,
`endif
        output iClr, iEn, iWindow, iWINLOG2, iA,
        input  oCnt, oProb, oValid, oSat
    );

    modport slave (
`ifdef ERROR_CHECK_EN
        input  iProb,
        output oErr, oMatch,
`endif
        input  iClr, iEn, iWindow, iWINLOG2, iA,
        output oCnt, oProb, oValid, oSat
    );
endinterface

// File: rtl/stoch_win_count.sv
// Counts ones of a stochastic bitstream over power-of-two windows and reports count + probability.
// Optional ERROR_CHECK_EN: compares the measured probability with the iProb latched at window start.
module stoch_win_count #(
    parameter int BITWIDTH     = 8,
    parameter int BITWIDTHLOG2 = 3,
    parameter int FBITWIDTH    = 4
) (
    input  logic             iClk,
    input  logic             iRstN,
    stoch_win_count_if.slave bus,
    output logic             oState
);
    localparam int SW = BITWIDTH + FBITWIDTH;
    localparam logic [SW-1:0]        SAT_LIM = SW'(1) << (FBITWIDTH - 1);
    localparam logic [FBITWIDTH-1:0] PMAX    = {1'b0, {(FBITWIDTH-1){1'b1}}};

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    state_t                  state;
    logic                    enD;
    logic [BITWIDTH-1:0]     ones;
    logic [BITWIDTH-1:0]     idx;
    logic [BITWIDTH-1:0]     winLen;
    logic [BITWIDTHLOG2-1:0] winLog;

    logic [BITWIDTH-1:0]     lenCur;
    logic [BITWIDTHLOG2-1:0] logCur;
    logic [BITWIDTH-1:0]     onesFinal;
    logic                    lastBit;
    logic [SW-1:0]           scaled;
    logic [FBITWIDTH-1:0]    probNext;
    logic                    satNext;

    // On the first bit of a window the latched length is not valid yet, so use the live inputs.
    always_comb begin
        lenCur    = (idx == '0) ? bus.iWindow : winLen;
        logCur    = (idx == '0) ? bus.iWINLOG2 : winLog;
        onesFinal = ones + BITWIDTH'(bus.iA);
        lastBit   = enD && (idx == lenCur - BITWIDTH'(1));
        scaled    = ({{FBITWIDTH{1'b0}}, onesFinal} << (FBITWIDTH - 1)) >> logCur;
        satNext   = (scaled >= SAT_LIM);
        probNext  = satNext ? PMAX : scaled[FBITWIDTH-1:0];
    end

`ifdef ERROR_CHECK_EN
    logic [FBITWIDTH-1:0] probLat;
    logic [FBITWIDTH-1:0] probCur;
    logic [FBITWIDTH-1:0] errNext;

    always_comb begin
        probCur = (idx == '0) ? bus.iProb : probLat;
        errNext = (probNext >= probCur) ? (probNext - probCur) : (probCur - probNext);
    end
`endif

    // oValid is a one-cycle strobe with no ready: the consumer samples oCnt/oProb/oSat while it
    // is high, and those outputs then hold until the next completed window.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state      <= IDLE;
            enD        <= 1'b0;
            ones       <= '0;
            idx        <= '0;
            winLen     <= '0;
            winLog     <= '0;
            bus.oCnt   <= '0;
            bus.oProb  <= '0;
            bus.oValid <= 1'b0;
            bus.oSat   <= 1'b0;
`ifdef ERROR_CHECK_EN
            probLat    <= '0;
            bus.oErr   <= '0;
            bus.oMatch <= 1'b0;
`endif
        end else begin
            enD        <= bus.iEn;
            bus.oValid <= 1'b0;
            if (bus.iClr) begin
                state     <= IDLE;
                ones      <= '0;
                idx       <= '0;
                bus.oCnt  <= '0;
                bus.oProb <= '0;
                bus.oSat  <= 1'b0;
`ifdef ERROR_CHECK_EN
                bus.oErr   <= '0;
                bus.oMatch <= 1'b0;
`endif
            end else if (!enD) begin
                state <= IDLE;
                ones  <= '0;
                idx   <= '0;
            end else begin
                state <= COUNT;
                if (idx == '0) begin
                    winLen <= bus.iWindow;
                    winLog <= bus.iWINLOG2;
`ifdef ERROR_CHECK_EN
                    probLat <= bus.iProb;
`endif
                end
                if (lastBit) begin
                    ones       <= '0;
                    idx        <= '0;
                    bus.oCnt   <= onesFinal;
                    bus.oProb  <= probNext;
                    bus.oSat   <= satNext;
                    bus.oValid <= 1'b1;
`ifdef ERROR_CHECK_EN
                    bus.oErr   <= errNext;
                    bus.oMatch <= (errNext == '0);
`endif
                end else begin
                    ones <= onesFinal;
                    idx  <= idx + BITWIDTH'(1);
                end
            end
        end
    end

    assign oState = state;
endmodule

// File: tb/tb_stoch_win_count.sv
// Bench for stoch_win_count: directed window scenarios followed by random back-to-back windows.
module tb_stoch_win_count;
    localparam int BW  = 8;
    localparam int BWL = 3;
    localparam int FW  = 4;
    localparam int W   = BW + FW + 1;

    logic iClk = 1'b0;
    logic iRstN;
    logic oState;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int n_assert = 0;
    int n_fail   = 0;

    stoch_win_count_if #(.BITWIDTH(BW), .BITWIDTHLOG2(BWL), .FBITWIDTH(FW)) bus();

    stoch_win_count #(.BITWIDTH(BW), .BITWIDTHLOG2(BWL), .FBITWIDTH(FW)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .bus    (bus),
        .oState (oState)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: probability is floor(cnt * 2^(FW-1) / 2^lg), saturating once the window is all ones.
    function automatic logic [W-1:0] model(input int cnt, input int lg);
        int   p;
        logic sat;
        if (cnt >= (1 << lg)) begin
            p   = (1 << (FW - 1)) - 1;
            sat = 1'b1;
        end else begin
            p   = (cnt * (1 << (FW - 1))) / (1 << lg);
            sat = 1'b0;
        end
        return {BW'(cnt), FW'(p), sat};
    endfunction

    task automatic cyc(input logic a);
        bus.iA = a;
        @(posedge iClk);
        #1;
    endtask

    task automatic set_win(input int lg);
        bus.iWINLOG2 = BWL'(lg);
        bus.iWindow  = BW'(1 << lg);
    endtask

    task automatic run_bits(input logic [127:0] bits, input int n);
        for (int i = 0; i < n; i++) cyc(bits[i]);
    endtask

    task automatic align();
        bus.iEn = 1'b1;
        cyc(1'($urandom_range(0, 1)));
    endtask

    task automatic stop_en();
        bus.iEn = 1'b0;
        cyc(1'($urandom_range(0, 1)));
        cyc(1'($urandom_range(0, 1)));
    endtask

    always @(negedge iClk) begin
        if (iRstN === 1'b1 && bus.oValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(bus.oValid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("cnt",  32'(bus.oCnt),  32'(mon_e[W-1 -: BW]));
                check("prob", 32'(bus.oProb), 32'(mon_e[FW:1]));
                check("sat",  32'(bus.oSat),  32'(mon_e[0]));
            end
        end
    end

    initial begin
        logic [127:0] rbits;
        int           rlg;
        int           rcnt;
        int           thr;

        iRstN    = 1'b0;
        bus.iClr = 1'b0;
        bus.iEn  = 1'b0;
        bus.iA   = 1'b0;
        set_win(3);
`ifdef ERROR_CHECK_EN
        bus.iProb = '0;
`endif
        repeat (3) @(posedge iClk);
        #1;
        iRstN = 1'b1;
        check("rst_cnt",   32'(bus.oCnt),   32'd0);
        check("rst_prob",  32'(bus.oProb),  32'd0);
        check("rst_valid", 32'(bus.oValid), 32'd0);
        check("rst_sat",   32'(bus.oSat),   32'd0);
        check("rst_state", 32'(oState),     32'd0);
`ifdef ERROR_CHECK_EN
        check("rst_err",   32'(bus.oErr),   32'd0);
`endif

        // All-ones window of 8: saturates, strobe on the 9th edge after iEn rises.
        exp_q.push_back(model(8, 3));
        set_win(3);
        align();
        run_bits('1, 7);
        check("t1_valid_early", 32'(bus.oValid), 32'd0);
        cyc(1'b1);
        check("t1_valid", 32'(bus.oValid), 32'd1);
        stop_en();

        // Alternating 1,0 over two back-to-back windows of 16.
        set_win(4);
        exp_q.push_back(model(8, 4));
        exp_q.push_back(model(8, 4));
        align();
        run_bits(128'h5555, 16);
        check("t2_valid_a", 32'(bus.oValid), 32'd1);
        run_bits(128'h5555, 16);
        check("t2_valid_b", 32'(bus.oValid), 32'd1);
        stop_en();

        // Window size changed mid-window only applies from the following window.
        set_win(3);
        exp_q.push_back(model(3, 3));
        exp_q.push_back(model(4, 3));
        exp_q.push_back(model(1, 2));
        align();
        run_bits(128'b0000_0111, 8);
        check("t3_valid_a", 32'(bus.oValid), 32'd1);
        run_bits(128'b101, 3);
        set_win(2);
        run_bits(128'b10001, 5);
        check("t3_oldlen_valid", 32'(bus.oValid), 32'd1);
        run_bits(128'b0001, 4);
        check("t3_newlen_valid", 32'(bus.oValid), 32'd1);
        stop_en();

        // Enable dropped after 5 bits: partial window discarded, fresh alignment on re-enable.
        set_win(3);
        exp_q.push_back(model(2, 3));
        align();
        run_bits('1, 5);
        bus.iEn = 1'b0;
        repeat (3) cyc(1'b1);
        bus.iEn = 1'b1;
        cyc(1'b1);
        run_bits(128'b0100_0100, 8);
        check("t4_valid", 32'(bus.oValid), 32'd1);
        stop_en();

        // Clear on the last bit suppresses the strobe and zeroes outputs.
`ifdef ERROR_CHECK_EN
        bus.iProb = 4'b0011;
`endif
        set_win(3);
        align();
        run_bits('1, 7);
        bus.iClr = 1'b1;
        cyc(1'b1);
        bus.iClr = 1'b0;
        check("t5_clr_valid", 32'(bus.oValid), 32'd0);
        check("t5_clr_cnt",   32'(bus.oCnt),   32'd0);
        check("t5_clr_prob",  32'(bus.oProb),  32'd0);
        check("t5_clr_sat",   32'(bus.oSat),   32'd0);
        check("t5_clr_state", 32'(oState),     32'd0);
        exp_q.push_back(model(4, 3));
        run_bits(128'b0101_0101, 8);
        check("t5_valid", 32'(bus.oValid), 32'd1);
`ifdef ERROR_CHECK_EN
        check("t5_err",   32'(bus.oErr),   32'd1);
        check("t5_match", 32'(bus.oMatch), 32'd0);
`endif

        // Asynchronous reset in the middle of a window holding five ones.
        run_bits('1, 5);
        #2;
        iRstN = 1'b0;
        #1;
        check("t6_rst_cnt",   32'(bus.oCnt),   32'd0);
        check("t6_rst_prob",  32'(bus.oProb),  32'd0);
        check("t6_rst_valid", 32'(bus.oValid), 32'd0);
        check("t6_rst_sat",   32'(bus.oSat),   32'd0);
        check("t6_rst_state", 32'(oState),     32'd0);
        @(posedge iClk);
        #1;
        iRstN = 1'b1;
        exp_q.push_back(model(6, 3));
        cyc(1'b1);
        run_bits(128'b0011_1111, 7);
        check("t6_no_early_valid", 32'(bus.oValid), 32'd0);
        cyc(1'b0);
        check("t6_valid", 32'(bus.oValid), 32'd1);

        // Random window sizes and densities, back to back.
        for (int w = 0; w < 6; w++) begin
            rlg   = $urandom_range(1, BW - 1);
            thr   = $urandom_range(0, 4);
            rbits = '0;
            rcnt  = 0;
            for (int i = 0; i < (1 << rlg); i++) begin
                rbits[i] = ($urandom_range(0, 3) < thr);
                rcnt += int'(rbits[i]);
            end
            exp_q.push_back(model(rcnt, rlg));
            set_win(rlg);
            run_bits(rbits, 1 << rlg);
            check("rnd_valid", 32'(bus.oValid), 32'd1);
        end
        stop_en();
        repeat (4) cyc(1'b0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
